memory_access_controller: RTL and testbench

Multi-cycle data-memory access controller between the single-cycle core's load/store datapath (after byte-enable logic) and a handshaked memory bus. Captures one load or store per instruction, runs the valid/ready request and response handshake, and returns `write_done`/`read_done` so the control unit holds `pc_stall` until the access retires. Replaces the zero-latency data memory, enabling slower SRAMs or memory-mapped peripherals without changing core timing elsewhere.

---
 rtl/memory_access_controller.sv | 130 +++++++++++++
 tb/tb_memory_access_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_controller.sv
// Data-memory access controller: one load/store per instruction over a
// valid/ready request bus, with done/fault pulses for the stall logic.
module memory_access_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic [31:0] read_data,
  output logic        read_done,
  output logic        write_done,
  output logic        busy,
  output logic        access_fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_write,
  output logic [31:0] bus_req_address,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wmask,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  input  logic        bus_resp_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DONE
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read; the read is dropped.
        if (memory_write || memory_read) begin
          state_d = REQ;
          wr_d    = memory_write;
          addr_d  = address & 32'hFFFF_FFFC;
          wdata_d = write_data;
          wmask_d = memory_write ? write_mask : 4'b0000;
          fault_d = 1'b0;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = WAIT_RESP;
          cnt_d   = '0;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 16'd1;
        // A response on the timeout cycle takes precedence.
        if (bus_resp_valid) begin
          state_d = DONE;
          fault_d = bus_resp_error;
          if (!wr_q && !bus_resp_error) begin
            rdata_d = bus_resp_rdata;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          fault_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign bus_req_valid   = (state_q == REQ);
  assign bus_req_write   = wr_q;
  assign bus_req_address = addr_q;
  assign bus_req_wdata   = wdata_q;
  assign bus_req_wmask   = wmask_q;
  assign read_data       = rdata_q;
  assign write_done      = (state_q == DONE) && wr_q;
  assign read_done       = (state_q == DONE) && !wr_q;
  assign access_fault    = (state_q == DONE) && fault_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Scoreboard bench for memory_access_controller: directed accesses push
// expected requests/completions; a negedge monitor pops and compares.
module tb_memory_access_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memory_read, memory_write;
  logic [31:0] address, write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        read_done, write_done, busy, access_fault;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [31:0] bus_req_address, bus_req_wdata;
  logic [3:0]  bus_req_wmask;
  logic        bus_resp_valid, bus_resp_error;
  logic [31:0] bus_resp_rdata;

  memory_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(rst_n),
    .memory_read(memory_read),
    .memory_write(memory_write),
    .address(address),
    .write_data(write_data),
    .write_mask(write_mask),
    .read_data(read_data),
    .read_done(read_done),
    .write_done(write_done),
    .busy(busy),
    .access_fault(access_fault),
    .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready),
    .bus_req_write(bus_req_write),
    .bus_req_address(bus_req_address),
    .bus_req_wdata(bus_req_wdata),
    .bus_req_wmask(bus_req_wmask),
    .bus_resp_valid(bus_resp_valid),
    .bus_resp_rdata(bus_resp_rdata),
    .bus_resp_error(bus_resp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    logic        wr;
    logic        fault;
    logic [31:0] rd;
    int          cyc;
  } done_t;

  req_t  exp_req[$];
  done_t exp_done[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] last_rd = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  req_t  mr;
  done_t md;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req_valid) begin
        checks++;
        if (exp_req.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req cyc=%0d addr=%h wr=%b",
                   cyc, bus_req_address, bus_req_write);
        end else begin
          mr = exp_req[0];
          if (bus_req_write !== mr.wr || bus_req_address !== mr.addr ||
              bus_req_wmask !== mr.mask ||
              (mr.wr && bus_req_wdata !== mr.wdata)) begin
            failures++;
            $display("FAIL req_fields cyc=%0d got=%b/%h/%h/%h exp=%b/%h/%h/%h",
                     cyc, bus_req_write, bus_req_address, bus_req_wdata,
                     bus_req_wmask, mr.wr, mr.addr, mr.wdata, mr.mask);
          end
          if (bus_req_ready) void'(exp_req.pop_front());
        end
      end
      if (access_fault && !read_done && !write_done) begin
        checks++;
        failures++;
        $display("FAIL lone_fault cyc=%0d got=1 exp=0", cyc);
      end
      if (read_done || write_done) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d rd=%b wr=%b",
                   cyc, read_done, write_done);
        end else begin
          md = exp_done.pop_front();
          if (read_done && write_done) begin
            failures++;
            $display("FAIL both_done cyc=%0d got=11 exp=one", cyc);
          end else if (write_done !== md.wr ||
                       access_fault !== md.fault ||
                       read_data !== md.rd || cyc != md.cyc) begin
            failures++;
            $display("FAIL done cyc=%0d got=w%b f%b rd=%h exp=c%0d w%b f%b rd=%h",
                     cyc, write_done, access_fault, read_data,
                     md.cyc, md.wr, md.fault, md.rd);
          end
        end
      end
    end
  end

  task automatic idle_bus();
    bus_req_ready  = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_rdata = 32'h0BAD_0BAD;
    bus_resp_error = 1'b0;
  endtask

  task automatic clear_core();
    memory_read  = 1'b0;
    memory_write = 1'b0;
    address      = 32'hFFFF_FFFF;
    write_data   = 32'h5555_5555;
    write_mask   = 4'hF;
  endtask

  // One access: ready after rdy REQ waits, response after rsp WAIT cycles.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, input int rdy,
                           input int rsp, input logic noresp,
                           input logic [31:0] rdata, input logic err);
    req_t  r;
    done_t d;
    int    t0, off;
    logic  f;
    @(posedge clk); #1;
    t0 = cyc;
    memory_read  = rd;
    memory_write = wr;
    address      = a;
    write_data   = wd;
    write_mask   = m;
    idle_bus();
    r.wr    = wr;
    r.addr  = {a[31:2], 2'b00};
    r.wdata = wd;
    r.mask  = wr ? m : 4'b0000;
    exp_req.push_back(r);
    f   = noresp || err;
    off = 3 + rdy + (noresp ? TO - 1 : rsp);
    if (!wr && !f) last_rd = rdata;
    d.wr    = wr;
    d.fault = f;
    d.rd    = last_rd;
    d.cyc   = t0 + off;
    exp_done.push_back(d);
    for (int c = 1; c <= off; c++) begin
      @(posedge clk); #1;
      clear_core();
      idle_bus();
      if (c <= rdy) begin
        // Junk responses while in REQ must be ignored.
        bus_resp_valid = 1'b1;
        bus_resp_error = 1'b1;
      end
      if (c == rdy + 1) bus_req_ready = 1'b1;
      if (!noresp && c == rdy + 2 + rsp) begin
        bus_resp_valid = 1'b1;
        bus_resp_rdata = rdata;
        bus_resp_error = err;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'b0, bus_req_valid}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_dones"}, {29'b0, read_done, write_done, access_fault}, 32'h0);
    chk({tag, "_rdata"}, read_data, 32'h0);
    chk({tag, "_addr"}, bus_req_address, 32'h0);
    chk({tag, "_wdata"}, bus_req_wdata, 32'h0);
    chk({tag, "_wmask_wr"}, {27'b0, bus_req_wmask, bus_req_write}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_core();
    memory_write = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Store, immediate ready/response
    do_access(1'b0, 1'b1, 32'h0000_0106, 32'h00AB_0000, 4'b0100,
              0, 0, 1'b0, 32'h0, 1'b0);
    // Load with 3 ready waits, response 2 cycles late; mask forced 0
    do_access(1'b1, 1'b0, 32'h2000_0013, 32'h1111_1111, 4'hF,
              3, 2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Timeout load: read_data stays DEADBEEF
    do_access(1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0,
              0, 0, 1'b1, 32'h0, 1'b0);
    // Store with bus error
    do_access(1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'b1111,
              1, 1, 1'b0, 32'h0, 1'b1);
    // Normal load right after
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0,
              0, 0, 1'b0, 32'h1234_5678, 1'b0);
    // Load with error: previous data kept
    do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'h0,
              0, 1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    // Response on the timeout cycle wins
    do_access(1'b1, 1'b0, 32'h0000_004C, 32'h0, 4'h0,
              0, TO - 1, 1'b0, 32'hCAFE_F00D, 1'b0);
    // Read and write together: single store
    do_access(1'b1, 1'b1, 32'h0000_0081, 32'h0000_BB00, 4'b0010,
              0, 0, 1'b0, 32'h0, 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'b0, busy}, 32'h0);
    end

    // Reset while in REQ
    @(posedge clk); #1;
    memory_read = 1'b1;
    address     = 32'h0000_0200;
    @(posedge clk); #1;
    clear_core();
    chk("mid_req_valid", {31'b0, bus_req_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, bus_req_valid}, 32'h0);
    chk("async_busy", {31'b0, busy}, 32'h0);
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("mid_reset");
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Recovery after reset
    do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0,
              2, 0, 1'b0, 32'h0F0F_0F0F, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("req_queue_empty", exp_req.size(), 32'h0);
    chk("done_queue_empty", exp_done.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
